decoder_sequencer: RTL
======================

DECODER_SEQUENCER -- requirements
Module: decoder_sequencer

Interface
REQ-001 Parameter INSTR_WIDTH, default 16, instruction word width; SHALL be >= 4.
REQ-002 Parameter OPCODE_LSB, default 12, bit position of the 4-bit opcode; opcode = instruction[OPCODE_LSB+3:OPCODE_LSB].
REQ-003 Parameter MEM_WAIT, default 2, extra cycles inserted for LOD/STR; legal range 0..15.
REQ-004 clock  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  asynchronous, active-low; low SHALL force reset state immediately, independent of clock.
REQ-006 instruction  in  INSTR_WIDTH  instruction word, sampled on accept.
REQ-007 in_valid  in  1  instruction present.
REQ-008 in_ready  out  1  block can accept; accept = in_valid & in_ready at a rising edge.
REQ-009 flush  in  1  discard the held or in-flight instruction.
REQ-010 out_valid  out  1  decoded controls valid.
REQ-011 out_ready  in  1  consumer takes controls; consume = out_valid & out_ready.
REQ-012 reg_write, mem_read, mem_write, jump  out  1 each  control strobes.
REQ-013 branch  out  2  01 branch-if-zero, 10 branch-if-negative, 00 none.
REQ-014 alu_op  out  4  ALU operation.
REQ-015 result_select  out  2  00 ALU, 01 PC+1, 10 memory, 11 immediate.
REQ-016 mem_busy  out  1  memory wait in progress; illegal  out  1  reserved opcode seen; halted  out  1  halt state.

Function
REQ-017 Decode: opcodes 0000-0111 SHALL give reg_write=1, alu_op=opcode, result_select=00.
REQ-018 1000 JMP: reg_write=1, jump=1, result_select=01; 1001 BRZ: branch=01; 1010 BRN: branch=10.
REQ-019 1100 LOD: reg_write=1, mem_read=1, result_select=10; 1101 STR: mem_write=1.
REQ-020 1110 SEL: reg_write=1, result_select=11, alu_op=0000; 1111 SEU: same with alu_op=1111.
REQ-021 1011 is reserved/illegal; every control not listed for an opcode SHALL be 0.
REQ-022 All control outputs SHALL be 0 whenever out_valid=0; when out_valid=1 they SHALL stay stable until consume or flush.
REQ-023 States IDLE, MEM, HOLD, HALT.
REQ-024 IDLE: in_ready=1. On accept: opcode 1011 -> HALT; LOD/STR with MEM_WAIT>0 -> MEM, counter=MEM_WAIT; else -> HOLD.
REQ-025 MEM: in_ready=0, out_valid=0, mem_busy=1; counter SHALL decrement each cycle; at counter=1 -> HOLD.
REQ-026 Latency accept-to-out_valid: 1 cycle for non-memory ops, 1+MEM_WAIT cycles for LOD/STR.
REQ-027 HOLD: out_valid=1, in_ready=out_ready; consume with accept SHALL load the next instruction per REQ-024 (back-to-back, no bubble); consume without accept -> IDLE; no consume -> stay.
REQ-028 HALT: illegal=1, halted=1, in_ready=0, out_valid=0; exit only via reset; flush ignored.
REQ-029 flush in IDLE/MEM/HOLD SHALL take priority over accept and consume: next state IDLE, counter 0, in_ready=0 during the flush cycle, in-flight instruction discarded with no out_valid.
REQ-030 Instructions SHALL never be dropped or duplicated except by flush; each accept yields exactly one out_valid period or HALT.

Reset
REQ-031 Reset SHALL force state IDLE, counter 0, all outputs 0; in_ready=1 from the first rising edge after reset release.
REQ-032 Reset asserted mid-MEM or in HALT SHALL abandon the operation with no out_valid on release.

Verification
REQ-033 Reset, then in_valid=1, instruction=0x2xxx (AND), out_ready=1 -> next cycle out_valid=1, reg_write=1, alu_op=0010, result_select=00.
REQ-034 Stream ADD, SUB, XOR, out_ready=1, in_valid held -> out_valid high 3 consecutive cycles, alu_op 0000, 0001, 0100, in_ready constantly 1.
REQ-035 LOD with MEM_WAIT=2 -> mem_busy=1 for 2 cycles, out_valid rises 3 cycles after accept with mem_read=1, result_select=10.
REQ-036 Opcode 1011 accepted -> illegal=1, halted=1, in_ready=0; further in_valid and flush ignored until reset pulse restores IDLE.
REQ-037 out_ready=0 holding a JMP for 5 cycles -> jump=1, result_select=01 stable, in_ready=0; then flush -> out_valid=0, all controls 0 next cycle.
REQ-038 reset low asynchronously during MEM (counter=1) -> outputs 0 immediately; after release no out_valid for the discarded LOD.

Source files
------------

// File: rtl/decoder_sequencer.sv
// Instruction decoder with a small sequencer: accepts one instruction at a time,
// inserts memory wait cycles for LOD/STR, holds decoded controls until consumed.
module decoder_sequencer #(
    parameter int unsigned INSTR_WIDTH = 16,
    parameter int unsigned OPCODE_LSB  = 12,
    parameter int unsigned MEM_WAIT    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [INSTR_WIDTH-1:0] instruction_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic                   flush_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic                   reg_write_o,
    output logic                   mem_read_o,
    output logic                   mem_write_o,
    output logic                   jump_o,
    output logic [1:0]             branch_o,
    output logic [3:0]             alu_op_o,
    output logic [1:0]             result_select_o,
    output logic                   mem_busy_o,
    output logic                   illegal_o,
    output logic                   halted_o
);
    localparam int unsigned OPC_W  = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned CTRL_W = 12;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MEM  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_HALT = 2'd3;

    localparam logic [3:0] OP_JMP = 4'b1000;
    localparam logic [3:0] OP_BRZ = 4'b1001;
    localparam logic [3:0] OP_BRN = 4'b1010;
    localparam logic [3:0] OP_ILL = 4'b1011;
    localparam logic [3:0] OP_LOD = 4'b1100;
    localparam logic [3:0] OP_STR = 4'b1101;
    localparam logic [3:0] OP_SEL = 4'b1110;
    localparam logic [3:0] OP_SEU = 4'b1111;

    if (INSTR_WIDTH < 4 || OPCODE_LSB + OPC_W > INSTR_WIDTH || MEM_WAIT > 15) begin : g_param_check
        $error("decoder_sequencer: illegal parameter combination");
    end

    // Control vector layout: {reg_write, mem_read, mem_write, jump, branch[1:0], alu_op[3:0], result_select[1:0]}
    function automatic logic [CTRL_W-1:0] decode(input logic [OPC_W-1:0] op);
        logic       rw, mr, mw, jp;
        logic [1:0] br, rs;
        logic [3:0] alu;
        rw = 1'b0; mr = 1'b0; mw = 1'b0; jp = 1'b0;
        br = 2'b00; rs = 2'b00; alu = 4'b0000;
        if (!op[3]) begin
            rw  = 1'b1;
            alu = op;
        end else begin
            case (op)
                OP_JMP:  begin rw = 1'b1; jp = 1'b1; rs = 2'b01; end
                OP_BRZ:  br = 2'b01;
                OP_BRN:  br = 2'b10;
                OP_LOD:  begin rw = 1'b1; mr = 1'b1; rs = 2'b10; end
                OP_STR:  mw = 1'b1;
                OP_SEL:  begin rw = 1'b1; rs = 2'b11; end
                OP_SEU:  begin rw = 1'b1; rs = 2'b11; alu = 4'b1111; end
                default: ;
            endcase
        end
        return {rw, mr, mw, jp, br, alu, rs};
    endfunction

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CTRL_W-1:0] out_ctrl_q;
    logic              init_q, out_valid_q, mem_busy_q, halted_q;

    logic [OPC_W-1:0]  opcode;
    logic              in_ready_c, accept;
    logic [1:0]        load_state;
    logic              unused_instr_bits;

    assign opcode            = instruction_i[OPCODE_LSB +: OPC_W];
    assign unused_instr_bits = ^instruction_i;

    // Destination of a freshly accepted instruction
    always_comb begin
        load_state = S_HOLD;
        if (opcode == OP_ILL) begin
            load_state = S_HALT;
        end else if ((opcode == OP_LOD || opcode == OP_STR) && (MEM_WAIT != 0)) begin
            load_state = S_MEM;
        end
    end

    always_comb begin
        in_ready_c = 1'b0;
        case (state_q)
            S_IDLE:  in_ready_c = init_q & ~flush_i;
            S_HOLD:  in_ready_c = out_ready_i & ~flush_i;
            default: in_ready_c = 1'b0;
        endcase
    end

    assign accept = in_valid_i & in_ready_c;

    // Next-state logic; flush outranks accept and consume everywhere except HALT
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ctrl_d  = ctrl_q;
        if (flush_i && state_q != S_HALT) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            ctrl_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_d = load_state;
                        cnt_d   = (load_state == S_MEM) ? CNT_W'(MEM_WAIT) : '0;
                        ctrl_d  = decode(opcode);
                    end
                end
                S_MEM: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (accept) begin
                        state_d = load_state;
                        cnt_d   = (load_state == S_MEM) ? CNT_W'(MEM_WAIT) : '0;
                        ctrl_d  = decode(opcode);
                    end else if (out_ready_i) begin
                        state_d = S_IDLE;
                        ctrl_d  = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // Registered outputs derived from the upcoming state so controls are zero outside HOLD
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_ctrl_q  <= '0;
            mem_busy_q  <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            init_q      <= 1'b1;
            out_valid_q <= (state_d == S_HOLD);
            out_ctrl_q  <= (state_d == S_HOLD) ? ctrl_d : '0;
            mem_busy_q  <= (state_d == S_MEM);
            halted_q    <= (state_d == S_HALT);
        end
    end

    assign in_ready_o  = in_ready_c;
    assign out_valid_o = out_valid_q;
    assign mem_busy_o  = mem_busy_q;
    assign illegal_o   = halted_q;
    assign halted_o    = halted_q;
    assign {reg_write_o, mem_read_o, mem_write_o, jump_o,
            branch_o, alu_op_o, result_select_o} = out_ctrl_q;

endmodule
